// File: rtl/chan_mux_seq.sv
// Registered N:1 channel mux with manual/auto select sequencer and 1-deep valid/ready output.
// Optional channel skip mask: define CHAN_MUX_SEQ_SKIP_MASK_EN to add the ch_mask input.
module chan_mux_seq #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 1,
  parameter int SEL_W  = $clog2(NUM_CH),
  parameter int DWELL  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     en,
`ifdef CHAN_MUX_SEQ_SKIP_MASK_EN
  input  logic [NUM_CH-1:0]        ch_mask,
`endif
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         cur_sel,
  output logic                     wrap,
  output logic                     sel_err
);

  localparam int unsigned          NCH      = NUM_CH;
  localparam int                   CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]     SEL_LAST = SEL_W'(NUM_CH - 1);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [SEL_W-1:0]  r_sel;
  logic              r_wrap;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic [SEL_W-1:0]  w_next;
  logic              w_found;
  logic              w_wrap_nx;
  logic              w_sel_ok;
  logic              w_load;

  assign w_sel_ok = (32'(sel_in) < 32'(NUM_CH));

`ifdef CHAN_MUX_SEQ_SKIP_MASK_EN
  // Circular search from r_sel+1; i == NCH lands back on r_sel itself.
  always_comb begin
    w_next  = r_sel;
    w_found = 1'b0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      if (!w_found && !ch_mask[SEL_W'((32'(r_sel) + i) % NCH)]) begin
        w_next  = SEL_W'((32'(r_sel) + i) % NCH);
        w_found = 1'b1;
      end
    end
    w_wrap_nx = w_found && (w_next <= r_sel);
  end
`else
  always_comb begin
    w_found   = 1'b1;
    w_wrap_nx = (r_sel == SEL_LAST);
    w_next    = w_wrap_nx ? '0 : r_sel + 1'b1;
  end
`endif

  // A fully masked scan stops producing samples; held data still drains.
  assign w_load = en && (!r_valid || out_ready) && !(mode && !w_found);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_wrap <= 1'b0;
      if (w_load) begin
        r_data  <= in_data[r_sel*DATA_W +: DATA_W];
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (!mode) begin
        r_cnt <= '0;
        if (w_sel_ok) r_sel <= sel_in;
        else          r_err <= 1'b1;
      end else if (en) begin
        if (r_cnt == CNT_LAST) begin
          r_cnt <= '0;
          if (w_found) begin
            r_sel  <= w_next;
            r_wrap <= w_wrap_nx;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign cur_sel   = r_sel;
  assign wrap      = r_wrap;
  assign sel_err   = r_err;

endmodule

// File: tb/tb_chan_mux_seq.sv
// Scoreboard bench for chan_mux_seq: stimulus queues expected samples, a monitor pops them on handshakes.
module tb_chan_mux_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       mode, en, out_ready;
  logic [2:0] sel_in;
  logic [0:0] out_data;
  logic       out_valid, wrap, sel_err;
  logic [2:0] cur_sel;

  logic [5:0] in6;
  logic       mode6, en6, ready6;
  logic [2:0] sel6;
  logic [0:0] d6;
  logic       v6, w6, e6;
  logic [2:0] cs6;

  int   n_vec = 0;
  int   n_err = 0;
  logic sbq[$];
  logic man_exp [1:9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

`ifdef CHAN_MUX_SEQ_SKIP_MASK_EN
  logic       modem, enm, readym;
  logic [7:0] maskm;
  logic [0:0] dm;
  logic       vm, wm, em;
  logic [2:0] csm;
  int         mask_exp [1:4] = '{2, 4, 6, 0};
`endif

  always #5 clk = ~clk;

  chan_mux_seq #(.NUM_CH(8), .DATA_W(1), .DWELL(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode), .sel_in(sel_in), .en(en),
`ifdef CHAN_MUX_SEQ_SKIP_MASK_EN
    .ch_mask(8'h00),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cur_sel(cur_sel), .wrap(wrap), .sel_err(sel_err)
  );

  chan_mux_seq #(.NUM_CH(6), .DATA_W(1), .DWELL(10)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(in6), .mode(mode6), .sel_in(sel6), .en(en6),
`ifdef CHAN_MUX_SEQ_SKIP_MASK_EN
    .ch_mask(6'h00),
`endif
    .out_data(d6), .out_valid(v6), .out_ready(ready6),
    .cur_sel(cs6), .wrap(w6), .sel_err(e6)
  );

`ifdef CHAN_MUX_SEQ_SKIP_MASK_EN
  chan_mux_seq #(.NUM_CH(8), .DATA_W(1), .DWELL(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(modem), .sel_in(3'd0), .en(enm),
    .ch_mask(maskm),
    .out_data(dm), .out_valid(vm), .out_ready(readym),
    .cur_sel(csm), .wrap(wm), .sel_err(em)
  );
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven at negedge; #1 later the pair (out_valid, out_ready) is what the next posedge consumes.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else                 chk("sb_data", 32'(out_data), 32'(sbq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;  in_data = 8'b01010101;
    mode = 1'b0;   en = 1'b0;  out_ready = 1'b0;  sel_in = '0;
    in6 = 6'b010101;  mode6 = 1'b0;  en6 = 1'b0;  ready6 = 1'b1;  sel6 = '0;
`ifdef CHAN_MUX_SEQ_SKIP_MASK_EN
    modem = 1'b0;  enm = 1'b0;  readym = 1'b1;  maskm = '0;
`endif
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_sel",   32'(cur_sel),   0);
    chk("rst_wrap",  32'(wrap),      0);
    chk("rst_err",   32'(sel_err),   0);

    // Manual sweep
    do_reset();
    mode = 1'b0;  en = 1'b1;  out_ready = 1'b1;  sel_in = 3'd0;  rst_n = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      chk("man_sel",   32'(cur_sel), (j - 1 > 7) ? 7 : j - 1);
      chk("man_valid", 32'(out_valid), 1);
      chk("man_wrap",  32'(wrap), 0);
      sbq.push_back(man_exp[j]);
      if (j <= 7) sel_in = 3'(j);
      if (j == 9) en = 1'b0;
    end
    @(negedge clk);
    chk("man_drop_valid", 32'(out_valid), 0);
    chk("man_drain", 32'(sbq.size()), 0);

    // Auto scan, 200 cycles
    do_reset();
    mode = 1'b1;  en = 1'b1;  out_ready = 1'b1;  rst_n = 1'b1;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      chk("auto_sel",  32'(cur_sel), (j / 10) % 8);
      chk("auto_wrap", 32'(wrap), (j % 80 == 0) ? 1 : 0);
      sbq.push_back((((j - 1) / 10) % 2 == 0) ? 1'b1 : 1'b0);
      if (j == 200) en = 1'b0;
    end
    @(negedge clk);
    chk("auto_drop_valid", 32'(out_valid), 0);
    chk("auto_drain", 32'(sbq.size()), 0);

    // Backpressure: held sample survives an input change, scan keeps moving
    do_reset();
    mode = 1'b1;  en = 1'b1;  out_ready = 1'b0;  rst_n = 1'b1;
    @(negedge clk);
    chk("bp_first_valid", 32'(out_valid), 1);
    chk("bp_first_data",  32'(out_data), 1);
    in_data = 8'b11111010;
    for (int j = 2; j <= 24; j++) begin
      @(negedge clk);
      chk("bp_hold", 32'(out_data), 1);
    end
    @(negedge clk);
    chk("bp_sel", 32'(cur_sel), 2);
    chk("bp_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    sbq.push_back(1'b1);
    @(negedge clk);
    sbq.push_back(1'b0);
    en = 1'b0;
    @(negedge clk);
    chk("bp_drop_valid", 32'(out_valid), 0);
    chk("bp_drain", 32'(sbq.size()), 0);

    // Asynchronous reset while a sample is held
    do_reset();
    mode = 1'b1;  en = 1'b1;  out_ready = 1'b0;  rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 1);
    chk("pre_rst_data",  32'(out_data), 1);
    chk("pre_rst_sel",   32'(cur_sel), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data",  32'(out_data), 0);
    chk("arst_sel",   32'(cur_sel), 0);
    chk("arst_wrap",  32'(wrap), 0);
    chk("arst_err",   32'(sel_err), 0);

    // Out-of-range select on a 6-channel instance
    do_reset();
    sel6 = 3'd3;  rst_n = 1'b1;
    @(negedge clk);
    chk("err_sel_a", 32'(cs6), 3);
    chk("err_flag_a", 32'(e6), 0);
    sel6 = 3'd7;
    @(negedge clk);
    chk("err_sel_b", 32'(cs6), 3);
    chk("err_flag_b", 32'(e6), 1);
    sel6 = 3'd2;
    @(negedge clk);
    chk("err_sel_c", 32'(cs6), 2);
    chk("err_flag_c", 32'(e6), 1);
    sel6 = 3'd6;
    @(negedge clk);
    chk("err_sel_d", 32'(cs6), 2);
    chk("err_flag_d", 32'(e6), 1);

`ifdef CHAN_MUX_SEQ_SKIP_MASK_EN
    // Skip mask with DWELL=1, then everything masked
    do_reset();
    modem = 1'b1;  enm = 1'b1;  readym = 1'b1;  maskm = 8'b10101010;  rst_n = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("mask_sel",  32'(csm), mask_exp[j]);
      chk("mask_wrap", 32'(wm), (j == 4) ? 1 : 0);
    end
    maskm = 8'hFF;
    for (int j = 5; j <= 6; j++) begin
      @(negedge clk);
      chk("allmask_sel",   32'(csm), 0);
      chk("allmask_wrap",  32'(wm), 0);
      chk("allmask_valid", 32'(vm), 0);
    end
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
